// File: rtl/run_rep_pkg.sv
// Shared types, default sizes and the saturating-increment helper for the
// run-length reporter slice.
package run_rep_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int DEPTH_DEF = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_RUN = 1'b1
    } run_state_t;

    // Stays at max once reached; callers cast the result back to their width.
    function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max);
        return (v >= max) ? v : v + 1;
    endfunction

endpackage

// File: rtl/run_rep_fifo.sv
// Synchronous record FIFO with a combinational head read; dout holds the last
// popped value while empty (0 after reset).
module run_rep_fifo #(
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [CNT_W-1:0] din,
    input  logic             pop,
    output logic [CNT_W-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CNT_W-1:0] hold;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? hold : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold   <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/run_len_reporter.sv
// Measures FINAL dwell runs from the one-hot detector, queues one length per run
// and checks detector legality. Define RUN_DROP_CNT_EN to add the drop_cnt port.
module run_len_reporter
    import run_rep_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             out1,
    input  logic             out2,
    output logic             rep_valid,
    input  logic             rep_ready,
    output logic [CNT_W-1:0] rep_data,
    output logic [CNT_W-1:0] run_cnt,
    output logic             ovf,
    output logic             err,
`ifdef RUN_DROP_CNT_EN
    output logic [CNT_W-1:0] drop_cnt,
`endif
    output logic             dbg_state
);
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    run_state_t       state;
    run_state_t       state_nxt;
    logic [CNT_W-1:0] len;
    logic             prev_out1;
    logic             push;
    logic             pop;
    logic             drop;
    logic             fifo_empty;
    logic             fifo_full;

    // Handshake: a record transfers on any edge with rep_valid & rep_ready;
    // while rep_valid=1 and rep_ready=0 rep_data is held and rep_valid stays up.
    assign rep_valid = ~fifo_empty;
    assign pop       = rep_valid & rep_ready;
    assign push      = (state == IN_RUN) & ~out2;
    assign drop      = push & fifo_full & ~pop;
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (out2)  state_nxt = IN_RUN;
            IN_RUN:  if (!out2) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len       <= '0;
            prev_out1 <= 1'b0;
            run_cnt   <= '0;
            ovf       <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            prev_out1 <= out1;
            if (state == IDLE && out2) begin
                len <= CNT_W'(1);
            end else if (state == IN_RUN && out2) begin
                len <= CNT_W'(sat_inc(32'(len), CNT_MAX));
            end
            if (push) begin
                run_cnt <= CNT_W'(sat_inc(32'(run_cnt), CNT_MAX));
            end
            if (drop) begin
                ovf <= 1'b1;
            end
            // FINAL must follow STATE_1, and the two indicators are one-hot.
            if ((out1 && out2) || (state == IDLE && out2 && !prev_out1)) begin
                err <= 1'b1;
            end
        end
    end

`ifdef RUN_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop) begin
            drop_cnt <= CNT_W'(sat_inc(32'(drop_cnt), CNT_MAX));
        end
    end
`endif

    run_rep_fifo #(
        .CNT_W(CNT_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (len),
        .pop  (pop),
        .dout (rep_data),
        .empty(fifo_empty),
        .full (fifo_full)
    );

endmodule

// File: tb/tb_run_len_reporter.sv
// Directed bench for run_len_reporter with hand-computed expectations.
module tb_run_len_reporter;
    import run_rep_pkg::*;

    logic       clk;
    logic       rst;
    logic       out1;
    logic       out2;
    logic       rep_valid;
    logic       rep_ready;
    logic [7:0] rep_data;
    logic [7:0] run_cnt;
    logic       ovf;
    logic       err;
    logic       dbg_state;
`ifdef RUN_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    run_len_reporter #(.CNT_W(8), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .out1     (out1),
        .out2     (out2),
        .rep_valid(rep_valid),
        .rep_ready(rep_ready),
        .rep_data (rep_data),
        .run_cnt  (run_cnt),
        .ovf      (ovf),
        .err      (err),
`ifdef RUN_DROP_CNT_EN
        .drop_cnt (drop_cnt),
`endif
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        out1 = 1'b0;
        out2 = 1'b0;
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    // Legal run: STATE_1 for one cycle, FINAL for n cycles, then the push edge.
    task automatic legal_run(input int n);
        out1 = 1'b1; out2 = 1'b0;
        step();
        out1 = 1'b0; out2 = 1'b1;
        repeat (n) step();
        out2 = 1'b0;
        step();
    endtask

    initial begin
        rep_ready = 1'b0;

        // 1: reset state
        do_reset(2);
        step();
        check("rst_valid", rep_valid, 0);
        check("rst_data", rep_data, 0);
        check("rst_run_cnt", run_cnt, 0);
        check("rst_ovf", ovf, 0);
        check("rst_err", err, 0);
        check("rst_state", dbg_state, IDLE);

        // 2: single legal run of length 3
        rep_ready = 1'b1;
        legal_run(3);
        check("r3_valid", rep_valid, 1);
        check("r3_data", rep_data, 3);
        check("r3_run_cnt", run_cnt, 1);
        check("r3_err", err, 0);
        step();
        check("r3_popped", rep_valid, 0);
        check("r3_hold", rep_data, 3);

        // 3: fill the FIFO with backpressure, overflow on the fifth run
        rep_ready = 1'b0;
        for (int i = 1; i <= 4; i++) legal_run(i);
        check("fill_valid", rep_valid, 1);
        check("fill_head", rep_data, 1);
        check("fill_ovf", ovf, 0);
        legal_run(5);
        check("ovf_set", ovf, 1);
        check("ovf_run_cnt", run_cnt, 6);
`ifdef RUN_DROP_CNT_EN
        check("drop_cnt", drop_cnt, 1);
`endif
        step();
        check("stall_data", rep_data, 1);
        rep_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_valid", rep_valid, 1);
            check("drain_data", rep_data, i);
            step();
        end
        check("drain_empty", rep_valid, 0);
        check("drain_hold", rep_data, 4);

        // 4: length saturates at 255
        legal_run(300);
        check("sat_valid", rep_valid, 1);
        check("sat_data", rep_data, 255);
        check("sat_run_cnt", run_cnt, 7);
        step();
        check("sat_popped", rep_valid, 0);

        // 5a: FINAL without preceding STATE_1
        out1 = 1'b0; out2 = 1'b1;
        step();
        check("err_no_s1", err, 1);
        out2 = 1'b0;
        step();
        check("err_run_measured", rep_data, 1);
        step();
        check("err_sticky", err, 1);
        // 5b: after reset, a legal entry then both indicators high together
        do_reset(1);
        check("err_cleared", err, 0);
        out1 = 1'b1;
        step();
        check("err_s1_only", err, 0);
        out2 = 1'b1;
        step();
        check("err_both_high", err, 1);
        out1 = 1'b0; out2 = 1'b0;
        repeat (3) step();
        check("err_stays", err, 1);

        // 6: reset in the middle of a run discards it
        do_reset(1);
        out1 = 1'b1;
        step();
        out1 = 1'b0; out2 = 1'b1;
        repeat (4) step();
        check("mid_state", dbg_state, IN_RUN);
        rst = 1'b1;
        step();
        rst = 1'b0;
        out2 = 1'b0;
        repeat (6) step();
        check("mid_no_record", rep_valid, 0);
        check("mid_run_cnt", run_cnt, 0);
        check("mid_state_idle", dbg_state, IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
